// File: rtl/arb_pkg.sv
// Shared types for the L2 port arbiter: ownership states and last-grant encoding.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin owner arbiter for the shared L2 port: forwards the owner's request,
// stalls the other L1 and mirrors the owner's activity to it as snoop strobes.
module l2_bus_arbiter
    import arb_pkg::*;
#(
    parameter int n  = 32,
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          L1A_read_request,
    input  logic          L1A_write_request,
    input  logic [aw-1:0] L1A_word_address,
    input  logic [n-1:0]  L1A_write_word,
    input  logic          L1B_read_request,
    input  logic          L1B_write_request,
    input  logic [aw-1:0] L1B_word_address,
    input  logic [n-1:0]  L1B_write_word,
    input  logic          L2_busy_in,
    input  logic [n-1:0]  L2_rdata_in,
    output logic          L2_read_request,
    output logic          L2_write_request,
    output logic [aw-1:0] L2_word_address,
    output logic [n-1:0]  L2_wdata,
    output logic [n-1:0]  L1A_read_word,
    output logic [n-1:0]  L1B_read_word,
    output logic          L2_busy_out_A,
    output logic          L2_busy_out_B,
    output logic          others_read_request_A,
    output logic          others_write_request_A,
    output logic          others_read_request_B,
    output logic          others_write_request_B,
    output logic          grant_A,
    output logic          grant_B,
    output logic [31:0]   arb_statistics,
    output logic [1:0]    state_dbg
);

    // Handshake: a request (read or write) is the L1's "valid"; the per-L1 busy
    // is its inverted "ready". A request must stay high until a cycle in which
    // that L1 is granted and its busy is low; the request is consumed there.

    arb_state_t  state;
    logic        last_grant;
    logic        req_a;
    logic        req_b;
    logic        win_a;
    logic        win_b;
    logic [15:0] grants_a;
    logic [15:0] grants_b;

    assign req_a = L1A_read_request | L1A_write_request;
    assign req_b = L1B_read_request | L1B_write_request;

    // On a tie the requester that did not own the port last time wins.
    assign win_a = (state == IDLE) && req_a && (!req_b || (last_grant == GRANT_B));
    assign win_b = (state == IDLE) && req_b && (!req_a || (last_grant == GRANT_A));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_B;
        end else begin
            case (state)
                IDLE: begin
                    if (win_a) begin
                        state <= OWN_A;
                    end else if (win_b) begin
                        state <= OWN_B;
                    end
                end
                OWN_A: begin
                    if (!req_a && !L2_busy_in) begin
                        state      <= IDLE;
                        last_grant <= GRANT_A;
                    end
                end
                OWN_B: begin
                    if (!req_b && !L2_busy_in) begin
                        state      <= IDLE;
                        last_grant <= GRANT_B;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter16 u_cnt_a (
        .clk   (clk),
        .reset (reset),
        .inc   (win_a),
        .count (grants_a)
    );

    sat_counter16 u_cnt_b (
        .clk   (clk),
        .reset (reset),
        .inc   (win_b),
        .count (grants_b)
    );

    always_comb begin
        L2_read_request        = 1'b0;
        L2_write_request       = 1'b0;
        L2_word_address        = '0;
        L2_wdata               = '0;
        L1A_read_word          = '0;
        L1B_read_word          = '0;
        L2_busy_out_A          = req_a;
        L2_busy_out_B          = req_b;
        others_read_request_A  = 1'b0;
        others_write_request_A = 1'b0;
        others_read_request_B  = 1'b0;
        others_write_request_B = 1'b0;
        grant_A                = 1'b0;
        grant_B                = 1'b0;
        case (state)
            OWN_A: begin
                grant_A                = 1'b1;
                L2_read_request        = L1A_read_request;
                L2_write_request       = L1A_write_request;
                L2_word_address        = L1A_word_address;
                L2_wdata               = L1A_write_word;
                L1A_read_word          = L2_rdata_in;
                L2_busy_out_A          = L2_busy_in;
                others_read_request_B  = L1A_read_request;
                others_write_request_B = L1A_write_request;
            end
            OWN_B: begin
                grant_B                = 1'b1;
                L2_read_request        = L1B_read_request;
                L2_write_request       = L1B_write_request;
                L2_word_address        = L1B_word_address;
                L2_wdata               = L1B_write_word;
                L1B_read_word          = L2_rdata_in;
                L2_busy_out_B          = L2_busy_in;
                others_read_request_A  = L1B_read_request;
                others_write_request_A = L1B_write_request;
            end
            default: ;
        endcase
    end

    assign arb_statistics = {grants_b, grants_a};
    assign state_dbg      = state;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: directed scenarios then random traffic, every cycle
// compared against an owner/last-winner model of the arbitration rules.
module tb_l2_bus_arbiter;

    localparam int N  = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_rd, a_wr, b_rd, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [N-1:0]  a_wdata, b_wdata;
    logic          l2_busy;
    logic [N-1:0]  l2_rdata;

    logic          o_l2_rd, o_l2_wr;
    logic [AW-1:0] o_l2_addr;
    logic [N-1:0]  o_l2_wdata, o_a_rword, o_b_rword;
    logic          o_busy_a, o_busy_b;
    logic          o_snp_rd_a, o_snp_wr_a, o_snp_rd_b, o_snp_wr_b;
    logic          o_grant_a, o_grant_b;
    logic [31:0]   o_stats;
    logic [1:0]    o_state_dbg;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the port (0 none, 1 A, 2 B), who won last, grant tallies.
    int m_owner = 0;
    int m_last  = 2;
    int m_ga    = 0;
    int m_gb    = 0;

    always #5 clk = ~clk;

    l2_bus_arbiter #(.n(N), .aw(AW)) dut (
        .clk                    (clk),
        .reset                  (rst),
        .L1A_read_request       (a_rd),
        .L1A_write_request      (a_wr),
        .L1A_word_address       (a_addr),
        .L1A_write_word         (a_wdata),
        .L1B_read_request       (b_rd),
        .L1B_write_request      (b_wr),
        .L1B_word_address       (b_addr),
        .L1B_write_word         (b_wdata),
        .L2_busy_in             (l2_busy),
        .L2_rdata_in            (l2_rdata),
        .L2_read_request        (o_l2_rd),
        .L2_write_request       (o_l2_wr),
        .L2_word_address        (o_l2_addr),
        .L2_wdata               (o_l2_wdata),
        .L1A_read_word          (o_a_rword),
        .L1B_read_word          (o_b_rword),
        .L2_busy_out_A          (o_busy_a),
        .L2_busy_out_B          (o_busy_b),
        .others_read_request_A  (o_snp_rd_a),
        .others_write_request_A (o_snp_wr_a),
        .others_read_request_B  (o_snp_rd_b),
        .others_write_request_B (o_snp_wr_b),
        .grant_A                (o_grant_a),
        .grant_B                (o_grant_b),
        .arb_statistics         (o_stats),
        .state_dbg              (o_state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        l2_busy = 0; l2_rdata = '0;
    endtask

    // Compare every output against the model for the current inputs, then
    // advance one clock and apply the arbitration rules to the model.
    task automatic step();
        logic req_a, req_b;
        int   w;
        #1;
        req_a = a_rd | a_wr;
        req_b = b_rd | b_wr;
        chk("grant_A", {31'd0, o_grant_a}, {31'd0, m_owner == 1});
        chk("grant_B", {31'd0, o_grant_b}, {31'd0, m_owner == 2});
        chk("l2_read", {31'd0, o_l2_rd},
            {31'd0, (m_owner == 1) ? a_rd : (m_owner == 2) ? b_rd : 1'b0});
        chk("l2_write", {31'd0, o_l2_wr},
            {31'd0, (m_owner == 1) ? a_wr : (m_owner == 2) ? b_wr : 1'b0});
        chk("l2_addr", {22'd0, o_l2_addr},
            {22'd0, (m_owner == 1) ? a_addr : (m_owner == 2) ? b_addr : 10'd0});
        chk("l2_wdata", o_l2_wdata,
            (m_owner == 1) ? a_wdata : (m_owner == 2) ? b_wdata : 32'd0);
        chk("rword_A", o_a_rword, (m_owner == 1) ? l2_rdata : 32'd0);
        chk("rword_B", o_b_rword, (m_owner == 2) ? l2_rdata : 32'd0);
        chk("busy_A", {31'd0, o_busy_a}, {31'd0, (m_owner == 1) ? l2_busy : req_a});
        chk("busy_B", {31'd0, o_busy_b}, {31'd0, (m_owner == 2) ? l2_busy : req_b});
        chk("snoop_rd_A", {31'd0, o_snp_rd_a}, {31'd0, (m_owner == 2) && b_rd});
        chk("snoop_wr_A", {31'd0, o_snp_wr_a}, {31'd0, (m_owner == 2) && b_wr});
        chk("snoop_rd_B", {31'd0, o_snp_rd_b}, {31'd0, (m_owner == 1) && a_rd});
        chk("snoop_wr_B", {31'd0, o_snp_wr_b}, {31'd0, (m_owner == 1) && a_wr});
        chk("stats", o_stats, {m_gb[15:0], m_ga[15:0]});
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_last = 2; m_ga = 0; m_gb = 0;
        end else if (m_owner == 0) begin
            w = 0;
            if (req_a && req_b) w = (m_last == 1) ? 2 : 1;
            else if (req_a)     w = 1;
            else if (req_b)     w = 2;
            m_owner = w;
            if (w == 1 && m_ga < 65535) m_ga++;
            if (w == 2 && m_gb < 65535) m_gb++;
        end else if (m_owner == 1 && !req_a && !l2_busy) begin
            m_owner = 0; m_last = 1;
        end else if (m_owner == 2 && !req_b && !l2_busy) begin
            m_owner = 0; m_last = 2;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        // Unchecked reset until the design's registers are defined.
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state with a check while reset is still asserted.
        do_reset();

        // Single requester: A reads 0x044.
        a_rd = 1; a_addr = 10'h044;
        step();
        #1;
        chk("single_grant_A", {31'd0, o_grant_a}, 32'd1);
        chk("single_addr", {22'd0, o_l2_addr}, 32'h044);
        chk("single_snoop_rd_B", {31'd0, o_snp_rd_b}, 32'd1);
        chk("single_busy_B", {31'd0, o_busy_b}, 32'd0);
        step();
        a_rd = 0;
        step();
        #1;
        chk("single_release_grant", {31'd0, o_grant_a}, 32'd0);
        chk("single_stats", o_stats, 32'h0000_0001);
        step();

        // Simultaneous first requests after reset: A write, B read.
        do_reset();
        a_wr = 1; a_addr = 10'h100; a_wdata = 32'h1234_5678;
        b_rd = 1; b_addr = 10'h200;
        step();
        #1;
        chk("tie_grant_A", {31'd0, o_grant_a}, 32'd1);
        chk("tie_busy_B", {31'd0, o_busy_b}, 32'd1);
        step();
        a_wr = 0;
        step();
        #1;
        chk("tie_idle_gap", {30'd0, o_grant_b, o_grant_a}, 32'd0);
        step();
        #1;
        chk("tie_grant_B", {31'd0, o_grant_b}, 32'd1);
        chk("tie_snoop_rd_A", {31'd0, o_snp_rd_a}, 32'd1);
        chk("tie_stats", o_stats, 32'h0001_0001);
        b_rd = 0;
        step();

        // Fairness: both keep requesting; each owner holds 3 cycles then drops.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            a_rd = 1; b_wr = 1;
            a_addr = 10'(t); b_addr = 10'(t + 16);
            step();
            for (int h = 0; h < 3; h++) begin
                #1;
                chk("fair_grant_A", {31'd0, o_grant_a}, {31'd0, (t % 2) == 0});
                chk("fair_grant_B", {31'd0, o_grant_b}, {31'd0, (t % 2) == 1});
                step();
            end
            if ((t % 2) == 0) a_rd = 0;
            else              b_wr = 0;
            step();
        end
        clear_inputs();
        step();

        // L2 stall: A's request drops while L2 stays busy for 5 cycles.
        do_reset();
        a_rd = 1; a_addr = 10'h3FF;
        step();
        a_rd = 0; l2_busy = 1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_grant_A", {31'd0, o_grant_a}, 32'd1);
            chk("stall_busy_A", {31'd0, o_busy_a}, 32'd1);
            step();
        end
        l2_busy = 0;
        step();
        #1;
        chk("stall_released", {31'd0, o_grant_a}, 32'd0);

        // Read steering to owner B.
        b_rd = 1; b_addr = 10'h055;
        step();
        l2_rdata = 32'hDEAD_BEEF;
        #1;
        chk("steer_rword_B", o_b_rword, 32'hDEAD_BEEF);
        chk("steer_rword_A", o_a_rword, 32'd0);
        step();

        // Reset mid-ownership of B, then a tie goes to A.
        rst = 1;
        step();
        rst = 0; a_rd = 1;
        #1;
        chk("rst_grant_B", {31'd0, o_grant_b}, 32'd0);
        chk("rst_stats", o_stats, 32'd0);
        step();
        #1;
        chk("rst_tie_grant_A", {31'd0, o_grant_a}, 32'd1);
        step();

        // Random traffic.
        for (int r = 0; r < 800; r++) begin
            rst      = ($urandom_range(0, 199) == 0);
            a_rd     = ($urandom_range(0, 2) == 0);
            a_wr     = ($urandom_range(0, 3) == 0);
            b_rd     = ($urandom_range(0, 2) == 0);
            b_wr     = ($urandom_range(0, 3) == 0);
            a_addr   = 10'($urandom);
            b_addr   = 10'($urandom);
            a_wdata  = $urandom;
            b_wdata  = $urandom;
            l2_busy  = ($urandom_range(0, 3) == 0);
            l2_rdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
